// File: rtl/rx_mac_interface.sv
// 10G MAC Rx client to ring-buffer writer: stores {descriptor, data qwords} per frame,
// publishes the committed write pointer and drops errored, oversized or overflowing frames.
module rx_mac_interface #(
    parameter int unsigned AW        = 9,
    parameter int unsigned MAX_BYTES = 9216
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [63:0]   rx_data,
    input  logic [7:0]    rx_data_valid,
    input  logic          rx_good_frame,
    input  logic          rx_bad_frame,
    output logic [AW-1:0] wr_addr,
    output logic [63:0]   wr_data,
    output logic          wr_en,
    output logic [AW-1:0] commited_wr_address,
    output logic          commited_wr_address_change,
    input  logic          rd_addr_updated,
    input  logic [AW-1:0] commited_rd_addr,
    output logic [31:0]   rx_dropped_frames
);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_COMMIT, S_DROP} state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [AW-1:0] r_cur_addr;
    logic [AW-1:0] r_sof_addr;
    logic [31:0]   r_byte_cnt;
    logic [AW-1:0] r_commit_addr;
    logic [1:0]    r_chg_cnt;
    logic [31:0]   r_dropped;

    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [63:0]   r_wr_data;

    logic          r_upd0;
    logic          r_upd1;
    logic [AW-1:0] r_rd0;
    logic [AW-1:0] r_rd1;

    logic [3:0]    w_popcnt;
    logic [32:0]   w_cnt_sum;
    logic          w_beat;
    logic          w_full;
    logic          w_over;
    logic          w_reject;
    logic          w_end;

    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [63:0]   w_wr_data;
    logic          w_accept;
    logic          w_rewind;
    logic          w_commit;

    always_comb begin
        w_popcnt = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_popcnt = w_popcnt + {3'b000, rx_data_valid[i]};
        end
    end

    assign w_cnt_sum = {1'b0, r_byte_cnt} + {29'b0, w_popcnt};
    assign w_beat    = (rx_data_valid != 8'h00);
    // One slot always stays empty so that write pointer == read pointer means empty.
    assign w_full    = (r_cur_addr == r_rd1);
    assign w_over    = (w_cnt_sum > 33'(MAX_BYTES));
    assign w_reject  = w_beat & (w_full | w_over);
    assign w_end     = rx_good_frame | rx_bad_frame;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_upd0 <= 1'b0;
            r_upd1 <= 1'b0;
            r_rd0  <= '0;
            r_rd1  <= '0;
        end else begin
            r_upd0 <= rd_addr_updated;
            r_upd1 <= r_upd0;
            r_rd0  <= commited_rd_addr;
            if (r_upd1) begin
                r_rd1 <= r_rd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_RECV: begin
                // A good pulse in IDLE with no beat is a zero-length frame and is ignored.
                if (w_beat || (r_state == S_RECV)) begin
                    if (w_reject) begin
                        w_next_state = w_end ? S_IDLE : S_DROP;
                    end else if (rx_bad_frame) begin
                        w_next_state = S_IDLE;
                    end else if (rx_good_frame) begin
                        w_next_state = S_COMMIT;
                    end else begin
                        w_next_state = S_RECV;
                    end
                end
            end
            S_COMMIT: w_next_state = S_IDLE;
            S_DROP:   w_next_state = w_end ? S_IDLE : S_DROP;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_cur_addr;
        w_wr_data = rx_data;
        w_accept  = 1'b0;
        w_rewind  = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            S_IDLE, S_RECV: begin
                if (w_beat || (r_state == S_RECV)) begin
                    w_accept = w_beat & ~w_reject;
                    w_wr_en  = w_accept;
                    w_rewind = (w_reject & w_end) | (~w_reject & rx_bad_frame);
                end
            end
            S_COMMIT: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_sof_addr;
                w_wr_data = {r_byte_cnt, 32'h0};
                w_commit  = 1'b1;
            end
            S_DROP: w_rewind = w_end;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_addr    <= AW'(1);
            r_sof_addr    <= '0;
            r_byte_cnt    <= '0;
            r_commit_addr <= '0;
            r_chg_cnt     <= '0;
            r_dropped     <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
        end else begin
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;

            if (w_commit) begin
                r_commit_addr <= r_cur_addr;
                r_sof_addr    <= r_cur_addr;
                r_cur_addr    <= r_cur_addr + 1'b1;
                r_byte_cnt    <= '0;
            end else if (w_rewind) begin
                r_cur_addr <= r_sof_addr + 1'b1;
                r_byte_cnt <= '0;
            end else if (w_accept) begin
                r_cur_addr <= r_cur_addr + 1'b1;
                r_byte_cnt <= w_cnt_sum[31:0];
            end

            if (w_rewind) begin
                r_dropped <= r_dropped + 1'b1;
            end

            if (w_commit) begin
                r_chg_cnt <= 2'd2;
            end else if (r_chg_cnt != 2'd0) begin
                r_chg_cnt <= r_chg_cnt - 1'b1;
            end
        end
    end

    assign wr_en                      = r_wr_en;
    assign wr_addr                    = r_wr_addr;
    assign wr_data                    = r_wr_data;
    assign commited_wr_address        = r_commit_addr;
    assign commited_wr_address_change = (r_chg_cnt != 2'd0);
    assign rx_dropped_frames          = r_dropped;

endmodule

// File: tb/tb_rx_mac_interface.sv
// Self-checking bench for rx_mac_interface on a 16-qword ring with a 64-byte frame limit;
// a reference ring model queues expected memory writes, frame tables check pointers/counters.
module tb_rx_mac_interface;

    localparam int unsigned AW   = 4;
    localparam int unsigned MAXB = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [63:0]   rx_data = '0;
    logic [7:0]    rx_data_valid = '0;
    logic          rx_good_frame = 1'b0;
    logic          rx_bad_frame = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          wr_en;
    logic [AW-1:0] commited_wr_address;
    logic          commited_wr_address_change;
    logic          rd_addr_updated = 1'b0;
    logic [AW-1:0] commited_rd_addr = '0;
    logic [31:0]   rx_dropped_frames;

    rx_mac_interface #(.AW(AW), .MAX_BYTES(MAXB)) dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .rx_data                    (rx_data),
        .rx_data_valid              (rx_data_valid),
        .rx_good_frame              (rx_good_frame),
        .rx_bad_frame               (rx_bad_frame),
        .wr_addr                    (wr_addr),
        .wr_data                    (wr_data),
        .wr_en                      (wr_en),
        .commited_wr_address        (commited_wr_address),
        .commited_wr_address_change (commited_wr_address_change),
        .rd_addr_updated            (rd_addr_updated),
        .commited_rd_addr           (commited_rd_addr),
        .rx_dropped_frames          (rx_dropped_frames)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } wr_t;

    typedef struct {
        int          nbeats;
        logic [7:0]  lastv;
        logic        good;
        logic        bad;
        logic        with_last;
        logic [AW-1:0] exp_commit;
        logic [31:0] exp_drop;
    } vec_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    // Reference ring model
    logic [AW-1:0] m_sof, m_cur, m_rd;
    int unsigned   m_cnt;
    bit            m_dropping, m_inframe;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n && wr_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL wr_unexpected: got addr %0d data %h expected no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", wr_data, e.data);
            end
        end
    end

    task automatic model_reset();
        m_sof = '0; m_cur = AW'(1); m_rd = '0; m_cnt = 0;
        m_dropping = 0; m_inframe = 0;
        exp_q.delete();
    endtask

    task automatic model_beat(input logic [63:0] d, input logic [7:0] v);
        int unsigned pc;
        pc = $countones(v);
        m_inframe = 1;
        if (!m_dropping) begin
            if ((m_cur == m_rd) || (m_cnt + pc > MAXB)) m_dropping = 1;
            else begin
                exp_q.push_back('{m_cur, d});
                m_cur = m_cur + 1'b1;
                m_cnt = m_cnt + pc;
            end
        end
    endtask

    task automatic model_end(input logic g, input logic b);
        if (!m_inframe) return;
        if (b || m_dropping) m_cur = m_sof + 1'b1;
        else if (g) begin
            exp_q.push_back('{m_sof, {m_cnt[31:0], 32'h0}});
            m_sof = m_cur;
            m_cur = m_cur + 1'b1;
        end
        m_cnt = 0; m_dropping = 0; m_inframe = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send_frame(input int n, input logic [7:0] midv, input logic [7:0] lastv,
                              input logic g, input logic b, input logic with_last);
        for (int i = 0; i < n; i++) begin
            rx_data       = {$urandom, $urandom};
            rx_data_valid = (i == n - 1) ? lastv : midv;
            rx_good_frame = (with_last && i == n - 1) ? g : 1'b0;
            rx_bad_frame  = (with_last && i == n - 1) ? b : 1'b0;
            model_beat(rx_data, rx_data_valid);
            if (with_last && i == n - 1) model_end(g, b);
            cyc();
        end
        rx_data_valid = '0;
        rx_good_frame = 1'b0;
        rx_bad_frame  = 1'b0;
        if (!with_last || n == 0) begin
            rx_good_frame = g;
            rx_bad_frame  = b;
            model_end(g, b);
            cyc();
            rx_good_frame = 1'b0;
            rx_bad_frame  = 1'b0;
        end
    endtask

    task automatic set_rd(input logic [AW-1:0] a);
        commited_rd_addr = a;
        rd_addr_updated  = 1'b1;
        cyc();
        rd_addr_updated  = 1'b0;
        idle(3);
        m_rd = a;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, wr_data, 64'd0);
        check({tag, "_commit"}, 64'(commited_wr_address), 64'd0);
        check({tag, "_change"}, 64'(commited_wr_address_change), 64'd0);
        check({tag, "_dropped"}, 64'(rx_dropped_frames), 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8, 8'hFF, 1'b0, 1'b1, 1'b0, 4'd9,  32'd1}; // 64 B then bad
        vecs[1] = '{3, 8'h07, 1'b1, 1'b0, 1'b1, 4'd13, 32'd1}; // reuses sof after bad
        vecs[2] = '{8, 8'hFF, 1'b1, 1'b0, 1'b0, 4'd6,  32'd1}; // exactly MAX_BYTES
        vecs[3] = '{9, 8'h01, 1'b1, 1'b0, 1'b0, 4'd6,  32'd2}; // MAX_BYTES + 1
        vecs[4] = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd6,  32'd2}; // zero-length good
        vecs[5] = '{1, 8'h01, 1'b1, 1'b0, 1'b1, 4'd8,  32'd2}; // single beat + good
        vecs[6] = '{2, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd8,  32'd3}; // good and bad together

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;
        cyc();
        check("post_reset_commit", 64'(commited_wr_address), 64'd0);

        // 60-byte frame into an empty ring, change strobe timing
        send_frame(8, 8'hFF, 8'h0F, 1'b1, 1'b0, 1'b1);
        check("t1_change_e0", 64'(commited_wr_address_change), 64'd0);
        cyc();
        check("t1_change_e1", 64'(commited_wr_address_change), 64'd1);
        check("t1_commit", 64'(commited_wr_address), 64'd9);
        cyc();
        check("t1_change_e2", 64'(commited_wr_address_change), 64'd1);
        cyc();
        check("t1_change_e3", 64'(commited_wr_address_change), 64'd0);
        check("t1_dropped", 64'(rx_dropped_frames), 64'd0);
        set_rd(4'd9);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].nbeats, 8'hFF, vecs[i].lastv, vecs[i].good, vecs[i].bad, vecs[i].with_last);
            idle(3);
            check($sformatf("vec%0d_commit", i), 64'(commited_wr_address), 64'(vecs[i].exp_commit));
            check($sformatf("vec%0d_dropped", i), 64'(rx_dropped_frames), 64'(vecs[i].exp_drop));
            set_rd(vecs[i].exp_commit);
        end

        // Ring full from empty: writes stop at 15, frame dropped
        reset_n = 1'b0;
        commited_rd_addr = '0;
        idle(2);
        model_reset();
        reset_n = 1'b1;
        cyc();
        send_frame(20, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("full_commit", 64'(commited_wr_address), 64'd0);
        check("full_dropped", 64'(rx_dropped_frames), 64'd1);

        // Wrap around the ring end
        send_frame(13, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("wrap_pre_commit", 64'(commited_wr_address), 64'd14);
        set_rd(4'd10);
        send_frame(3, 8'hFF, 8'h0F, 1'b1, 1'b0, 1'b1);
        idle(3);
        check("wrap_commit", 64'(commited_wr_address), 64'd2);

        // Read pointer synchroniser latency
        commited_rd_addr = 4'd5;
        rd_addr_updated  = 1'b1;
        cyc();
        rd_addr_updated  = 1'b0;
        cyc();
        check("rdsync_early", 64'(dut.r_rd1), 64'd10);
        cyc();
        check("rdsync_taken", 64'(dut.r_rd1), 64'd5);
        commited_rd_addr = 4'd7;
        idle(5);
        check("rdsync_hold", 64'(dut.r_rd1), 64'd5);
        set_rd(4'd2);

        // Back-to-back frames at minimum gap, then reset mid-frame
        send_frame(4, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        idle(2);
        send_frame(3, 8'hFF, 8'h3F, 1'b1, 1'b0, 1'b1);
        idle(2);
        check("b2b_commit", 64'(commited_wr_address), 64'd11);
        send_frame(2, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        check("midreset_pending", 64'(exp_q.size()), 64'd0);
        commited_rd_addr = '0;
        idle(2);
        model_reset();
        reset_n = 1'b1;
        cyc();
        send_frame(2, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        idle(3);
        check("recover_commit", 64'(commited_wr_address), 64'd3);
        check("recover_dropped", 64'(rx_dropped_frames), 64'd0);
        check("end_pending", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
